// File: rtl/gsm_pkg.sv
// Shared constants and types for the GSM modem receive path.
// Holds ASCII codes, the matched response strings and the UART RX state encoding.
package gsm_pkg;

    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] GT    = 8'h3E;
    localparam logic [7:0] COMMA = 8'h2C;

    localparam logic [15:0] STR_OK    = "OK";
    localparam logic [39:0] STR_ERROR = "ERROR";
    localparam logic [47:0] STR_CMTI  = "+CMTI:";

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_t;

    function automatic logic is_ascii_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser plus a baud-counting RX FSM.
// Emits one-cycle rx_valid / frame_err strobes after the stop-bit sample.
module uart_rx_byte
    import gsm_pkg::*;
#(
    parameter int unsigned DIV = 5208
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

    rx_state_t     state;
    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RxIdle;
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_prev   <= rx_sync;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                RxIdle: begin
                    if (rx_prev && !rx_sync) begin
                        state   <= RxStart;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end
                end
                RxStart: begin
                    // Mid-start-bit check rejects short glitches on the idle line
                    if (cnt == HALF_M1) begin
                        cnt   <= '0;
                        state <= rx_sync ? RxIdle : RxData;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RxData: begin
                    if (cnt == FULL_M1) begin
                        cnt     <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
                            state <= RxStop;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RxStop: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= RxIdle;
                        if (rx_sync) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= shreg;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= RxIdle;
            endcase
        end
    end

endmodule

// File: rtl/gsm_resp_rx.sv
// GSM modem receive path: UART bytes are assembled into lines and classified
// as OK / ERROR / +CMTI, with immediate detection of the '>' send prompt.
module gsm_resp_rx
    import gsm_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned MAX_LINE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       resp_ok,
    output logic       resp_error,
    output logic       resp_prompt,
    output logic       resp_cmti,
    output logic [7:0] sms_index,
    output logic       line_ovf
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned LW  = $clog2(MAX_LINE + 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LINE);

    uart_rx_byte #(
        .DIV(DIV)
    ) u_uart_rx_byte (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .frame_err(frame_err)
    );

    // Only the first six bytes ever take part in a string compare, so only
    // those are kept; len still counts the whole line for overflow detection.
    logic [7:0]    head [6];
    logic [LW-1:0] len;
    logic          ovf;
    logic          comma_seen;
    logic          tail_ok;
    logic [1:0]    ndig;
    logic [9:0]    idx_acc;

    logic is_term;
    logic is_digit;
    logic line_ok;
    logic line_error;
    logic line_cmti;

    assign is_term    = (rx_byte == CR) || (rx_byte == LF);
    assign is_digit   = is_ascii_digit(rx_byte);
    assign line_ok    = (len == LW'(2)) && ({head[0], head[1]} == STR_OK);
    assign line_error = (len == LW'(5)) &&
                        ({head[0], head[1], head[2], head[3], head[4]} == STR_ERROR);
    assign line_cmti  = (len >= LW'(6)) &&
                        ({head[0], head[1], head[2], head[3], head[4], head[5]} == STR_CMTI) &&
                        comma_seen && tail_ok && (ndig != 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                head[i] <= '0;
            end
            len         <= '0;
            ovf         <= 1'b0;
            comma_seen  <= 1'b0;
            tail_ok     <= 1'b0;
            ndig        <= '0;
            idx_acc     <= '0;
            resp_ok     <= 1'b0;
            resp_error  <= 1'b0;
            resp_prompt <= 1'b0;
            resp_cmti   <= 1'b0;
            line_ovf    <= 1'b0;
            sms_index   <= '0;
        end else begin
            resp_ok     <= 1'b0;
            resp_error  <= 1'b0;
            resp_prompt <= 1'b0;
            resp_cmti   <= 1'b0;
            line_ovf    <= 1'b0;
            if (rx_valid) begin
                if (is_term) begin
                    if (len != '0) begin
                        if (ovf) begin
                            line_ovf <= 1'b1;
                        end else if (line_ok) begin
                            resp_ok <= 1'b1;
                        end else if (line_error) begin
                            resp_error <= 1'b1;
                        end else if (line_cmti) begin
                            resp_cmti <= 1'b1;
                            sms_index <= (idx_acc > 10'd255) ? 8'hFF : idx_acc[7:0];
                        end
                        len        <= '0;
                        ovf        <= 1'b0;
                        comma_seen <= 1'b0;
                        tail_ok    <= 1'b0;
                        ndig       <= '0;
                        idx_acc    <= '0;
                    end
                end else if (rx_byte == GT && len == '0) begin
                    // The modem sends "> " without a terminator
                    resp_prompt <= 1'b1;
                end else if (len < LEN_MAX) begin
                    if (len < LW'(6)) begin
                        head[3'(len)] <= rx_byte;
                    end
                    len <= len + 1'b1;
                    // Track the digits following the most recent comma
                    if (rx_byte == COMMA) begin
                        comma_seen <= 1'b1;
                        tail_ok    <= 1'b1;
                        ndig       <= '0;
                        idx_acc    <= '0;
                    end else if (is_digit) begin
                        if (ndig == 2'd3) begin
                            tail_ok <= 1'b0;
                        end else begin
                            ndig    <= ndig + 1'b1;
                            idx_acc <= 10'(idx_acc * 10'd10) + {6'd0, rx_byte[3:0]};
                        end
                    end else begin
                        tail_ok <= 1'b0;
                    end
                end else begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule
